vpu_store_unit: RTL and testbench
=================================

Name: vpu_store_unit

Overview:
Vector store engine for the VPU: the write-direction counterpart of the VPU LOAD path into the TPC shared SRAM. It accepts a store command from the VPU sequencer and reads consecutive vector registers through a dedicated VRF read port. It then writes each 256-bit register to SRAM at base + i*stride, using a valid/ready write handshake toward the SRAM bank arbiter. Bank decode of the 20-bit word address is done downstream; for 4 banks, addr[1:0] selects the bank and addr>>2 selects the word.

Parameters:
DATA_WIDTH, 256, SRAM and vector register width in bits
ADDR_WIDTH, 20, SRAM word address width
VREG_BITS, 5, vector register index width (32 registers)
LEN_WIDTH, 16, width of the length and stride fields

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  store command valid
cmd_ready  output  1  unit idle and able to accept a command
cmd_vs  input  VREG_BITS  first source vector register
cmd_addr  input  ADDR_WIDTH  base SRAM word address
cmd_len  input  LEN_WIDTH  number of registers/words to store
cmd_stride  input  LEN_WIDTH  address increment per word (unsigned)
vrf_re  output  1  VRF read enable
vrf_raddr  output  VREG_BITS  VRF read index
vrf_rdata  input  DATA_WIDTH  VRF read data, valid the cycle after vrf_re
sram_we  output  1  SRAM write request
sram_addr  output  ADDR_WIDTH  SRAM write address
sram_wdata  output  DATA_WIDTH  SRAM write data
sram_ready  input  1  arbiter accepts the write this cycle
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
error  output  1  one-cycle pulse with done on a rejected command

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0 except cmd_ready=1; counters and data buffer cleared. Reset asserted mid-store abandons the store immediately: no further writes, and no done pulse.
- States: IDLE, RD, CAP, WR, FIN, ERR.
- cmd_ready = (state==IDLE). A command is accepted on the edge where cmd_valid and cmd_ready are both high.
  - The command's fields are latched into base/vs/len/stride registers; the index counter i is set to 0.
- Validation at accept: a command is rejected if cmd_len==0 or cmd_vs+cmd_len>32 (compare at 6+ bits; no wrap of the register index).
  - Rejected command goes to ERR: one cycle with done=1, error=1, then IDLE. No vrf_re or sram_we is ever issued for it.
- RD: vrf_re=1, vrf_raddr=vs+i; next state is CAP.
- CAP: vrf_rdata is latched into wbuf at the end of the cycle; next state is WR.
- WR: sram_we=1, sram_addr = (base + i*stride) mod 2^ADDR_WIDTH, sram_wdata=wbuf.
  - Address wraps modulo 2^20. Running address is kept by accumulation, not a multiplier.
  - While sram_ready=0: sram_we, sram_addr and sram_wdata are held stable, and no vrf_re is issued.
  - On sram_ready=1 with words remaining: i increments and vrf_re is issued in the same cycle with vrf_raddr=vs+i+1. Next state is CAP.
  - On sram_ready=1 for the last word (i==len-1): next state is FIN.
- FIN: done=1 for one cycle; then IDLE.
- Latency: the first sram_we is asserted 3 cycles after the accept edge (RD, CAP, then WR). With sram_ready held high, steady-state throughput is one word per 2 cycles.
- busy=1 in every state except IDLE.
- cmd_valid is ignored while busy.

Decomposition:
- Shared package (vpu_pkg): state encoding constants and the VOP_STORE opcode value (8'h31). Width parameters come from the TPC top.
- No sub-module required. The address accumulator plus index counter is small enough to stay inline.

Test Plan:
- Single word: vrf[0]=8x32b pattern EEEEEEEE..00006666; store vs=0, addr=0x00020, len=1, stride=0, ready high.
  -> Exactly one write: addr 0x00020, data equal to vrf[0], first sram_we 3 cycles after accept.
  -> done pulse in the following cycle; the word lands in bank0 word 8.
- Strided multi-word: vs=2, addr=0x100, len=3, stride=4.
  -> Writes go to 0x100, 0x104, 0x108 with data vrf[2], vrf[3], vrf[4].
  -> sram_we edges are 2 cycles apart; done after the third write is accepted.
- Backpressure: hold sram_ready=0 for 5 cycles during the second word.
  -> sram_we, sram_addr and sram_wdata stay constant.
  -> No vrf_re during the stall; the sequence resumes correctly.
- Rejected commands: len=0, and separately vs=30 with len=3.
  -> Never any sram_we or vrf_re.
  -> done=error=1 for exactly one cycle, 1 cycle after accept.
- Address wrap: addr=0xFFFFC, stride=4, len=2 -> writes to 0xFFFFC, then 0x00000.
- Reset mid-store and round-trip:
  -> Assert rst_n=0 during WR of word 2 of 4: outputs clear immediately, no done pulse, cmd_ready=1 after release.
  -> Then issue a new store followed by a VPU LOAD of the same address: the reloaded register equals the source register.

Source files
------------

// File: rtl/vpu_store_unit_pkg.sv
// Shared definitions for the VPU store engine: FSM state encoding, opcode value,
// and the command validation rule.
package vpu_store_unit_pkg;

    localparam logic [7:0] VOP_STORE = 8'h31;

    localparam int unsigned NUM_VREGS = 32;

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StRd   = 3'd1;
    localparam logic [2:0] StCap  = 3'd2;
    localparam logic [2:0] StWr   = 3'd3;
    localparam logic [2:0] StFin  = 3'd4;
    localparam logic [2:0] StErr  = 3'd5;

    // Wide compare so vs+len never wraps the register index.
    function automatic logic cmd_invalid(input int unsigned vs, input int unsigned len);
        return (len == 0) || (vs + len > NUM_VREGS);
    endfunction

endpackage

// File: rtl/vpu_store_unit_if.sv
// Command, VRF read port and SRAM write port of the VPU store engine.
// master: the store unit; slave: sequencer / VRF / SRAM arbiter side.
interface vpu_store_unit_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned VREG_BITS  = 5,
    parameter int unsigned LEN_WIDTH  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [VREG_BITS-1:0]  cmd_vs;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [LEN_WIDTH-1:0]  cmd_stride;

    logic                  vrf_re;
    logic [VREG_BITS-1:0]  vrf_raddr;
    logic [DATA_WIDTH-1:0] vrf_rdata;

    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic                  sram_ready;

    modport master (
        input  cmd_valid, cmd_vs, cmd_addr, cmd_len, cmd_stride,
        input  vrf_rdata, sram_ready,
        output cmd_ready, vrf_re, vrf_raddr, sram_we, sram_addr, sram_wdata
    );

    modport slave (
        output cmd_valid, cmd_vs, cmd_addr, cmd_len, cmd_stride,
        output vrf_rdata, sram_ready,
        input  cmd_ready, vrf_re, vrf_raddr, sram_we, sram_addr, sram_wdata
    );

endinterface

// File: rtl/vpu_store_unit.sv
// VPU vector store engine: reads len consecutive vector registers starting at vs
// and writes each one to SRAM at base + i*stride (address wraps modulo 2^ADDR_WIDTH).
module vpu_store_unit
    import vpu_store_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 20,
    parameter int unsigned VREG_BITS  = 5,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    vpu_store_unit_if.master    bus,
    output logic                busy,
    output logic                done,
    output logic                error
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [VREG_BITS-1:0]  vs_q, vs_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  stride_q, stride_d;
    logic [LEN_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wbuf_q, wbuf_d;

    logic last;
    logic rd_en;

    assign last = (idx_q == len_q - LEN_WIDTH'(1));

    // Next-state: command latch, index counter, running address accumulator.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        vs_d     = vs_q;
        len_d    = len_q;
        stride_d = stride_q;
        idx_d    = idx_q;
        wbuf_d   = wbuf_q;
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    vs_d     = bus.cmd_vs;
                    addr_d   = bus.cmd_addr;
                    len_d    = bus.cmd_len;
                    stride_d = bus.cmd_stride;
                    idx_d    = '0;
                    state_d  = cmd_invalid(32'(bus.cmd_vs), 32'(bus.cmd_len)) ? StErr : StRd;
                end
            end
            StRd:  state_d = StCap;
            StCap: begin
                wbuf_d  = bus.vrf_rdata;
                state_d = StWr;
            end
            StWr: begin
                if (bus.sram_ready) begin
                    if (last) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = idx_q + LEN_WIDTH'(1);
                        addr_d  = addr_q + ADDR_WIDTH'(stride_q);
                        state_d = StCap;
                    end
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            vs_q     <= '0;
            len_q    <= '0;
            stride_q <= '0;
            idx_q    <= '0;
            wbuf_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            vs_q     <= vs_d;
            len_q    <= len_d;
            stride_q <= stride_d;
            idx_q    <= idx_d;
            wbuf_q   <= wbuf_d;
        end
    end

    // Next register is prefetched in the same cycle the current write is accepted.
    assign rd_en = (state_q == StRd) || ((state_q == StWr) && bus.sram_ready && !last);

    // Outputs decoded from state; buses are zeroed when not in use.
    always_comb begin
        bus.cmd_ready  = (state_q == StIdle);
        busy           = (state_q != StIdle);
        done           = (state_q == StFin) || (state_q == StErr);
        error          = (state_q == StErr);
        bus.vrf_re     = rd_en;
        bus.vrf_raddr  = '0;
        if (rd_en) begin
            bus.vrf_raddr = vs_q + idx_q[VREG_BITS-1:0] + VREG_BITS'(state_q == StWr);
        end
        bus.sram_we    = (state_q == StWr);
        bus.sram_addr  = (state_q == StWr) ? addr_q : '0;
        bus.sram_wdata = (state_q == StWr) ? wbuf_q : '0;
    end

endmodule

// File: tb/tb_vpu_store_unit.sv
// Bench for vpu_store_unit: VRF and SRAM models, a transaction-level reference
// model checked every cycle, plus directed literal expectations.
module tb_vpu_store_unit;

    localparam int DW = 256;
    localparam int AW = 20;
    localparam int VB = 5;
    localparam int LW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done, error;

    vpu_store_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VREG_BITS(VB), .LEN_WIDTH(LW)) bus ();

    vpu_store_unit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VREG_BITS(VB), .LEN_WIDTH(LW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   addr;
        logic [DW-1:0] data;
    } wr_t;

    logic [DW-1:0] vrf [32];
    logic [DW-1:0] sram_mem [int];
    wr_t           exp_q [$];
    int            wr_cyc [$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            stall_cnt = 0;
    bit            done_due = 0;
    bit            err_due = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mem_rd(input int a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return '0;
    endfunction

    // VRF read port: data one cycle after the read enable.
    always @(posedge clk) begin
        if (bus.vrf_re) bus.vrf_rdata <= vrf[bus.vrf_raddr];
    end

    // SRAM bank model and cycle counter.
    always @(posedge clk) begin
        cyc++;
        if (rst_n && bus.sram_we && bus.sram_ready) sram_mem[int'(bus.sram_addr)] = bus.sram_wdata;
    end

    // Reference model: expected write list per command, compared every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            done_due = 0;
            err_due  = 0;
        end else begin
            chk("done", {255'b0, done}, {255'b0, done_due});
            chk("error", {255'b0, error}, {255'b0, err_due});
            done_due = 0;
            err_due  = 0;
            if (bus.sram_we && !bus.sram_ready) begin
                stall_cnt++;
                chk("vrf_re_during_stall", {255'b0, bus.vrf_re}, '0);
            end
            if (exp_q.size() == 0) begin
                chk("sram_we_idle", {255'b0, bus.sram_we}, '0);
                chk("vrf_re_idle", {255'b0, bus.vrf_re}, '0);
            end else if (bus.sram_we) begin
                chk("sram_addr", DW'(bus.sram_addr), DW'(exp_q[0].addr));
                chk("sram_wdata", bus.sram_wdata, exp_q[0].data);
                if (bus.sram_ready) begin
                    void'(exp_q.pop_front());
                    wr_cnt++;
                    wr_cyc.push_back(cyc);
                    if (exp_q.size() == 0) done_due = 1;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                int unsigned vs, len, base, stride;
                vs = bus.cmd_vs; len = bus.cmd_len; base = bus.cmd_addr; stride = bus.cmd_stride;
                if (len == 0 || vs + len > 32) begin
                    done_due = 1;
                    err_due  = 1;
                end else begin
                    for (int unsigned i = 0; i < len; i++)
                        exp_q.push_back(wr_t'{(base + i * stride) & 32'h000F_FFFF, vrf[vs + i]});
                end
            end
        end
    end

    task automatic issue(input int vs, input int len, input int addr, input int stride);
        int t = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("cmd_ready_before_issue", {255'b0, bus.cmd_ready}, 256'd1);
        bus.cmd_vs     = VB'(vs);
        bus.cmd_len    = LW'(len);
        bus.cmd_addr   = AW'(addr);
        bus.cmd_stride = LW'(stride);
        bus.cmd_valid  = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("idle_timeout", {255'b0, busy}, '0);
    endtask

    task automatic wait_wr(input int n);
        int t = 0;
        while (wr_cnt < n && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("write_wait_timeout", DW'(wr_cnt), DW'(n));
    endtask

    initial begin
        logic [AW-1:0] a;
        int t;
        for (int i = 0; i < 32; i++)
            vrf[i] = {4{32'hC0DE0000 | 32'(i), 32'h0000A000 + 32'(i * 7)}};
        vrf[0] = 256'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888_00006666;
        bus.cmd_valid  = 1'b0;
        bus.cmd_vs     = '0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.cmd_stride = '0;
        bus.sram_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {255'b0, bus.cmd_ready}, 256'd1);
        chk("rst_busy", {255'b0, busy}, '0);
        chk("rst_done", {255'b0, done}, '0);
        chk("rst_error", {255'b0, error}, '0);
        chk("rst_sram_we", {255'b0, bus.sram_we}, '0);
        chk("rst_vrf_re", {255'b0, bus.vrf_re}, '0);
        rst_n = 1'b1;

        // Single word, latency pinned by hand
        issue(0, 1, 32'h20, 0);
        @(negedge clk);
        chk("t1_c1_vrf_re", {255'b0, bus.vrf_re}, 256'd1);
        chk("t1_c1_raddr", DW'(bus.vrf_raddr), '0);
        chk("t1_c1_we", {255'b0, bus.sram_we}, '0);
        @(negedge clk);
        chk("t1_c2_we", {255'b0, bus.sram_we}, '0);
        @(negedge clk);
        chk("t1_c3_we", {255'b0, bus.sram_we}, 256'd1);
        chk("t1_c3_addr", DW'(bus.sram_addr), 256'h20);
        chk("t1_c3_data", bus.sram_wdata,
            256'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888_00006666);
        a = bus.sram_addr;
        chk("t1_bank", DW'(a[1:0]), '0);
        chk("t1_bank_word", DW'(a >> 2), 256'd8);
        @(negedge clk);
        chk("t1_c4_done", {255'b0, done}, 256'd1);
        chk("t1_c4_error", {255'b0, error}, '0);
        wait_idle();
        chk("t1_mem", mem_rd(32'h20),
            256'hEEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888_00006666);

        // Strided multi-word
        wr_cyc.delete();
        issue(2, 3, 32'h100, 4);
        wait_idle();
        chk("t2_nwrites", DW'(wr_cyc.size()), 256'd3);
        if (wr_cyc.size() >= 3) begin
            chk("t2_gap01", DW'(wr_cyc[1] - wr_cyc[0]), 256'd2);
            chk("t2_gap12", DW'(wr_cyc[2] - wr_cyc[1]), 256'd2);
        end
        chk("t2_mem100", mem_rd(32'h100), {4{32'hC0DE0002, 32'h0000A00E}});
        chk("t2_mem104", mem_rd(32'h104), {4{32'hC0DE0003, 32'h0000A015}});
        chk("t2_mem108", mem_rd(32'h108), {4{32'hC0DE0004, 32'h0000A01C}});

        // Backpressure during the second word
        wr_cnt = 0;
        stall_cnt = 0;
        issue(5, 3, 32'h200, 1);
        wait_wr(1);
        bus.sram_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.sram_ready = 1'b1;
        wait_idle();
        chk("t3_stall_cycles", DW'(stall_cnt), 256'd5);
        chk("t3_writes", DW'(wr_cnt), 256'd3);
        chk("t3_mem201", mem_rd(32'h201), {4{32'hC0DE0006, 32'h0000A02A}});
        chk("t3_mem202", mem_rd(32'h202), {4{32'hC0DE0007, 32'h0000A031}});

        // Rejected commands
        issue(0, 0, 32'h40, 1);
        @(negedge clk);
        chk("t4a_done", {255'b0, done}, 256'd1);
        chk("t4a_error", {255'b0, error}, 256'd1);
        @(negedge clk);
        chk("t4a_done_clear", {255'b0, done}, '0);
        issue(30, 3, 32'h50, 1);
        @(negedge clk);
        chk("t4b_done", {255'b0, done}, 256'd1);
        chk("t4b_error", {255'b0, error}, 256'd1);
        @(negedge clk);
        chk("t4b_error_clear", {255'b0, error}, '0);
        chk("t4_no_write", {255'b0, sram_mem.exists(32'h50) || sram_mem.exists(32'h40)}, '0);

        // Address wrap
        issue(10, 2, 32'hFFFFC, 4);
        wait_idle();
        chk("t5_memFFFFC", mem_rd(32'hFFFFC), {4{32'hC0DE000A, 32'h0000A046}});
        chk("t5_mem0", mem_rd(0), {4{32'hC0DE000B, 32'h0000A04D}});

        // Reset during the second word of four
        wr_cnt = 0;
        issue(8, 4, 32'h300, 2);
        wait_wr(1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.sram_we && t < 10);
        chk("t6_reached_wr", {255'b0, bus.sram_we}, 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_we", {255'b0, bus.sram_we}, '0);
        chk("t6_rst_vrf_re", {255'b0, bus.vrf_re}, '0);
        chk("t6_rst_busy", {255'b0, busy}, '0);
        chk("t6_rst_done", {255'b0, done}, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_cmd_ready", {255'b0, bus.cmd_ready}, 256'd1);
        chk("t6_no_word2", {255'b0, sram_mem.exists(32'h302)}, '0);

        // Round trip: store then reload the same addresses
        issue(8, 4, 32'h300, 2);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            logic [DW-1:0] reload;
            reload = mem_rd(32'h300 + 2 * i);
            chk($sformatf("t7_reload%0d", i), reload, vrf[8 + i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
